// File: rtl/pwm_ramp_sequencer.sv
// Purpose : steps a PWM compare value toward a commanded target once per PWM period, then holds it there for a programmed number of periods.
// Latency : compare_value, compare_write and done are registered one cycle after the sampled period_tick; a command enters RAMP the cycle after acceptance.
// Backpressure: cmd_ready is high only in IDLE with abort and reset inactive; commands offered at any other time are held off.
// Optional feature: define PWM_RAMP_BOUNCE_EN to add cmd_bounce (ping-pong between start and target until abort/reset).

module pwm_ramp_sequencer #(
  parameter int WIDTH      = 16,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  period_tick,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_target,
  input  logic [WIDTH-1:0]      cmd_step,
  input  logic [HOLD_WIDTH-1:0] cmd_hold,
`ifdef PWM_RAMP_BOUNCE_EN
  input  logic                  cmd_bounce,
`endif
  input  logic                  abort,
  output logic [WIDTH-1:0]      compare_value,
  output logic                  compare_write,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      target_q, target_d;
  logic [WIDTH-1:0]      start_q, start_d;
  logic [WIDTH-1:0]      step_q, step_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      cmp_q, cmp_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic                  bounce_q;

  // Ramp arithmetic, one bit wider than the compare value so nothing wraps.
  logic [WIDTH:0]   tgt_x, cur_x, step_x, dist_x, next_x;
  logic             going_up;
  logic             arrive;
  logic [WIDTH-1:0] ramp_next;

  logic accept;

  assign cmd_ready = (state_q == IDLE) && !abort && rst;
  assign accept    = cmd_valid && cmd_ready;

  // Distance to target and the candidate next compare value for a ramp tick.
  always_comb begin
    tgt_x    = {1'b0, target_q};
    cur_x    = {1'b0, cmp_q};
    step_x   = {1'b0, step_q};
    going_up = (tgt_x > cur_x);
    dist_x   = going_up ? (tgt_x - cur_x) : (cur_x - tgt_x);
    arrive   = (dist_x <= step_x);
    if (arrive) begin
      next_x = tgt_x;
    end else if (going_up) begin
      next_x = cur_x + step_x;
    end else begin
      next_x = cur_x - step_x;
    end
    // A set top bit would mean a wrap; landing on the target is the only
    // safe answer. Unreachable while dist > step, kept as a hard guard.
    ramp_next = next_x[WIDTH] ? target_q : next_x[WIDTH-1:0];
  end

  // Next-state and datapath update; abort outranks every other event.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    start_d  = start_q;
    step_d   = step_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    cmp_d    = cmp_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A tick landing in the accept cycle is deliberately ignored.
        if (accept) begin
          target_d = cmd_target;
          start_d  = cmp_q;
          step_d   = (cmd_step == '0) ? WIDTH'(1) : cmd_step;
          hold_d   = cmd_hold;
          state_d  = RAMP;
        end
      end

      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (period_tick) begin
          cmp_d = ramp_next;
          wr_d  = (ramp_next != cmp_q);
          if (arrive) begin
            state_d = HOLD;
            cnt_d   = hold_q;
          end
        end
      end

      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (period_tick) begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
            if (bounce_q) begin
              // Swap endpoints and run the ramp back the other way.
              target_d = start_q;
              start_d  = target_q;
              state_d  = RAMP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - HOLD_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any command in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      start_q  <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      cmp_q    <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      start_q  <= start_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
    end
  end

`ifdef PWM_RAMP_BOUNCE_EN
  // Bounce mode is captured with the rest of the command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bounce_q <= 1'b0;
    end else if (accept) begin
      bounce_q <= cmd_bounce;
    end
  end
`else
  assign bounce_q = 1'b0;
`endif

  assign compare_value = cmp_q;
  assign compare_write = wr_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: ramps up/down, step-0 handling,
// abort, equal-target hold, mid-ramp reset, and bounce when enabled.
`timescale 1ns/1ps
module tb_pwm_ramp_sequencer;

  localparam int WIDTH      = 16;
  localparam int HOLD_WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic                  period_tick;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [WIDTH-1:0]      cmd_target;
  logic [WIDTH-1:0]      cmd_step;
  logic [HOLD_WIDTH-1:0] cmd_hold;
  logic                  cmd_bounce;
  logic                  abort;
  logic [WIDTH-1:0]      compare_value;
  logic                  compare_write;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  pwm_ramp_sequencer #(
    .WIDTH      (WIDTH),
    .HOLD_WIDTH (HOLD_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .period_tick   (period_tick),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_target    (cmd_target),
    .cmd_step      (cmd_step),
    .cmd_hold      (cmd_hold),
`ifdef PWM_RAMP_BOUNCE_EN
    .cmd_bounce    (cmd_bounce),
`endif
    .abort         (abort),
    .compare_value (compare_value),
    .compare_write (compare_write),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: one-cycle tick, check registered results, idle gap.
  task automatic do_tick(input string tag, input int exp_val, input bit exp_wr, input bit exp_done);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    check({tag, ".value"}, 32'(compare_value), exp_val);
    check({tag, ".write"}, 32'(compare_write), 32'(exp_wr));
    check({tag, ".done"},  32'(done),          32'(exp_done));
    @(negedge clk);
  endtask

  // Called at a negedge: offer a command (optionally with a tick in the same cycle).
  task automatic send_cmd(input string tag, input int tgt, input int stp, input int hld,
                          input bit bnc, input bit with_tick, input int exp_val);
    cmd_target  = WIDTH'(tgt);
    cmd_step    = WIDTH'(stp);
    cmd_hold    = HOLD_WIDTH'(hld);
    cmd_bounce  = bnc;
    cmd_valid   = 1'b1;
    period_tick = with_tick;
    #1;
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid   = 1'b0;
    period_tick = 1'b0;
    check({tag, ".busy"},  32'(busy),          32'd1);
    check({tag, ".value"}, 32'(compare_value), exp_val);
    check({tag, ".write"}, 32'(compare_write), 32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    period_tick = 1'b0;
    cmd_valid   = 1'b0;
    cmd_target  = '0;
    cmd_step    = '0;
    cmd_hold    = '0;
    cmd_bounce  = 1'b0;
    abort       = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.value", 32'(compare_value), 32'd0);
    check("rst.write", 32'(compare_write), 32'd0);
    check("rst.done",  32'(done),          32'd0);
    check("rst.busy",  32'(busy),          32'd0);
    check("rst.ready", 32'(cmd_ready),     32'd0);

    rst = 1'b1;
    @(negedge clk);
    check("rel.ready", 32'(cmd_ready),     32'd1);
    check("rel.busy",  32'(busy),          32'd0);
    check("rel.value", 32'(compare_value), 32'd0);
    repeat (3) do_tick("idle", 0, 1'b0, 1'b0);

    // 0 -> 100 step 30 hold 2, with a tick in the accept cycle (ignored).
    send_cmd("up", 100, 30, 2, 1'b0, 1'b1, 0);
    do_tick("up30",  30,  1'b1, 1'b0);
    do_tick("up60",  60,  1'b1, 1'b0);
    do_tick("up90",  90,  1'b1, 1'b0);
    do_tick("up100", 100, 1'b1, 1'b0);
    check("up.hold_busy", 32'(busy), 32'd1);
    do_tick("hold1", 100, 1'b0, 1'b0);
    do_tick("hold2", 100, 1'b0, 1'b0);
    do_tick("hold3", 100, 1'b0, 1'b1);
    check("up.idle_busy", 32'(busy), 32'd0);
    check("up.done_low",  32'(done), 32'd0);

    // 100 -> 0 with step 0 (treated as 1).
    send_cmd("s0", 0, 0, 0, 1'b0, 1'b0, 100);
    for (int k = 1; k <= 100; k++) begin
      do_tick("s0", 100 - k, 1'b1, 1'b0);
    end
    do_tick("s0.end", 0, 1'b0, 1'b1);
    check("s0.busy", 32'(busy), 32'd0);

    // Back to 100 in one step, then down by 40.
    send_cmd("to100", 100, 100, 0, 1'b0, 1'b0, 0);
    do_tick("to100.v", 100, 1'b1, 1'b0);
    do_tick("to100.d", 100, 1'b0, 1'b1);
    send_cmd("dn", 0, 40, 0, 1'b0, 1'b0, 100);
    do_tick("dn60", 60, 1'b1, 1'b0);
    do_tick("dn20", 20, 1'b1, 1'b0);
    do_tick("dn0",  0,  1'b1, 1'b0);
    do_tick("dn.d", 0,  1'b0, 1'b1);

    // Abort mid-ramp, colliding with a tick: abort wins.
    send_cmd("ab", 100, 30, 0, 1'b0, 1'b0, 0);
    do_tick("ab30", 30, 1'b1, 1'b0);
    do_tick("ab60", 60, 1'b1, 1'b0);
    abort       = 1'b1;
    period_tick = 1'b1;
    @(negedge clk);
    abort       = 1'b0;
    period_tick = 1'b0;
    check("ab.busy",  32'(busy),          32'd0);
    check("ab.value", 32'(compare_value), 32'd60);
    check("ab.write", 32'(compare_write), 32'd0);
    check("ab.done",  32'(done),          32'd0);
    @(negedge clk);
    check("ab.done2", 32'(done), 32'd0);

    // cmd_valid together with abort in IDLE: refused, no side effect.
    abort      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_target = WIDTH'(10);
    cmd_step   = WIDTH'(5);
    cmd_hold   = '0;
    #1;
    check("abv.ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("abv.busy",  32'(busy),          32'd0);
    check("abv.value", 32'(compare_value), 32'd60);
    do_tick("abv.tick", 60, 1'b0, 1'b0);

    // 60 -> 50, then a command whose target equals the current value.
    send_cmd("to50", 50, 10, 0, 1'b0, 1'b0, 60);
    do_tick("to50.v", 50, 1'b1, 1'b0);
    do_tick("to50.d", 50, 1'b0, 1'b1);
    send_cmd("eq", 50, 5, 0, 1'b0, 1'b0, 50);
    do_tick("eq.t1", 50, 1'b0, 1'b0);
    do_tick("eq.t2", 50, 1'b0, 1'b1);
    check("eq.busy", 32'(busy), 32'd0);

    // Reset asserted mid-ramp.
    send_cmd("mr", 200, 10, 0, 1'b0, 1'b0, 50);
    do_tick("mr60", 60, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("mr.value", 32'(compare_value), 32'd0);
    check("mr.busy",  32'(busy),          32'd0);
    check("mr.ready", 32'(cmd_ready),     32'd0);
    @(negedge clk);
    check("mr.done",  32'(done),          32'd0);
    check("mr.write", 32'(compare_write), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mr.rel_ready", 32'(cmd_ready), 32'd1);
    do_tick("mr.idle", 0, 1'b0, 1'b0);

`ifdef PWM_RAMP_BOUNCE_EN
    // Bounce between 0 and 50 until abort.
    send_cmd("bn", 50, 25, 0, 1'b1, 1'b0, 0);
    do_tick("bn25a", 25, 1'b1, 1'b0);
    do_tick("bn50",  50, 1'b1, 1'b0);
    do_tick("bnd1",  50, 1'b0, 1'b1);
    do_tick("bn25b", 25, 1'b1, 1'b0);
    do_tick("bn0",   0,  1'b1, 1'b0);
    do_tick("bnd2",  0,  1'b0, 1'b1);
    do_tick("bn25c", 25, 1'b1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("bn.busy",  32'(busy),          32'd0);
    check("bn.value", 32'(compare_value), 32'd25);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the width of compare, target and step values and match the PWM channel compare width.
REQ-002 Parameter HOLD_WIDTH, default 8, SHALL set the width of the hold-period count.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 period_tick  input  1  SHALL be a one-cycle pulse marking each PWM period wrap.
REQ-006 cmd_valid  input  1  SHALL request a ramp command.
REQ-007 cmd_ready  output  1  SHALL indicate a command can be accepted.
REQ-008 cmd_target  input  WIDTH  SHALL give the ramp end value.
REQ-009 cmd_step  input  WIDTH  SHALL give the per-period increment magnitude.
REQ-010 cmd_hold  input  HOLD_WIDTH  SHALL give extra hold periods at the target.
REQ-011 abort  input  1  SHALL synchronously cancel the active command.
REQ-012 compare_value  output  WIDTH  SHALL drive the PWM channel compare value (registered).
REQ-013 compare_write  output  1  SHALL pulse for one cycle whenever compare_value changes.
REQ-014 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-015 done  output  1  SHALL pulse for one cycle at normal hold completion.

Function
REQ-016 The FSM SHALL have states IDLE, RAMP and HOLD.
REQ-017 cmd_ready SHALL equal (state==IDLE) && !abort && rst.
REQ-018 On cmd_valid && cmd_ready, the block SHALL latch target, step (0 latched as 1), hold and start = compare_value, then enter RAMP the next cycle.
REQ-019 A period_tick in the accept cycle SHALL be ignored.
REQ-020 In RAMP, on period_tick: if |target - compare_value| <= step, compare_value SHALL become target and the state SHALL become HOLD with counter = hold; otherwise compare_value SHALL move by step toward target.
REQ-021 Ramp arithmetic SHALL be computed WIDTH+1 bits wide; compare_value SHALL never overshoot target or wrap.
REQ-022 compare_value and compare_write SHALL update in the cycle after the sampled period_tick; compare_write SHALL stay low if the value is unchanged.
REQ-023 In HOLD, on period_tick: if counter==0, the block SHALL enter IDLE and pulse done; otherwise the counter SHALL decrement (hold N SHALL last N+1 ticks).
REQ-024 abort SHALL have highest priority: any non-IDLE state SHALL go to IDLE next cycle with compare_value retained, and done and compare_write SHALL not assert.
REQ-025 abort in IDLE SHALL have no effect.

Reset
REQ-026 While rst=0: state=IDLE, compare_value=0, counter=0, compare_write=0, done=0, busy=0, cmd_ready=0.
REQ-027 Reset asserted mid-ramp SHALL discard the command immediately, without a done pulse.

Configuration
REQ-028 With macro PWM_RAMP_BOUNCE_EN defined, input cmd_bounce (1 bit) SHALL exist and be latched on accept.
REQ-029 With PWM_RAMP_BOUNCE_EN and latched bounce=1, HOLD expiry SHALL pulse done, swap start and target, and re-enter RAMP; the cycle SHALL repeat until abort or reset.
REQ-030 Without PWM_RAMP_BOUNCE_EN, cmd_bounce SHALL be absent and behaviour SHALL equal bounce=0.

Verification
REQ-031 Release reset -> compare_value=0, busy=0, cmd_ready=1; no compare_write while ticks arrive in IDLE.
REQ-032 From 0, cmd target=100 step=30 hold=2 -> values 30,60,90,100 on successive ticks with one compare_write each; done pulses on the 3rd tick after reaching 100; then IDLE.
REQ-033 From 100, target=0 step=0 -> step treated as 1; 100 ticks to reach 0 with no underflow; from 100, target=0 step=40 -> values 60,20,0.
REQ-034 Abort one cycle after value reaches 60 (target 100) -> IDLE next cycle, compare_value stays 60, no done; cmd_valid with abort in the same cycle -> not accepted.
REQ-035 target equals current (50), hold=0 -> no compare_write; done after 2 ticks.
REQ-036 With PWM_RAMP_BOUNCE_EN: 0 -> target 50, step 25, hold 0, bounce 1 -> values 25,50,25,0,25,... with done at each hold expiry until abort.
